// File: rtl/co2_alarm_ctrl_pkg.sv
// Shared smart-home definitions: FSM encodings, timer width and default tick
// constants used by the CO2 detector, alarm controller and status panel.
package co2_alarm_ctrl_pkg;

    localparam int TMR_W = 16;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_VENT  = 3'd1;
    localparam logic [2:0] ST_ALARM = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;

    localparam int DEF_WIN_TICKS     = 60;
    localparam int DEF_FAN_MIN_TICKS = 30;
    localparam int DEF_QUIET_TICKS   = 120;

endpackage

// File: rtl/co2_alarm_ctrl_tick_timer.sv
// Loadable down-counter that decrements on the time-base strobe and holds at 0.
// Priority: load, then clear, then decrement.
module co2_alarm_ctrl_tick_timer
    import co2_alarm_ctrl_pkg::*;
(
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    input  logic             clr,
    input  logic             dec,
    output logic             zero,
    output logic             last
);

    logic [TMR_W-1:0] value;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (clr) begin
            value <= '0;
        end else if (dec && (value != '0)) begin
            value <= value - TMR_W'(1);
        end
    end

    // last marks the value that the next decrement turns into 0
    assign zero = (value == '0);
    assign last = (value == TMR_W'(1));

endmodule

// File: rtl/co2_alarm_ctrl.sv
// CO2 alarm controller: turns detector match pulses into fan, lamp and buzzer
// drive with a hit window, minimum fan time, acknowledge and quiet release.
module co2_alarm_ctrl
    import co2_alarm_ctrl_pkg::*;
#(
    parameter int HIT_THR       = 3,
    parameter int WIN_TICKS     = DEF_WIN_TICKS,
    parameter int FAN_MIN_TICKS = DEF_FAN_MIN_TICKS,
    parameter int QUIET_TICKS   = DEF_QUIET_TICKS,
    parameter int CNT_W         = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             det,
    input  logic             tick,
    input  logic             ack,
    output logic             fan,
    output logic             alarm,
    output logic             buzzer,
    output logic [CNT_W-1:0] event_cnt,
    output logic [2:0]       state_dbg
);

    localparam logic [3:0] HIT_THR_V = 4'(HIT_THR);

    logic [2:0] state, state_n;
    logic [3:0] hits, hits_n, hits_inc;
    logic       buzzer_n;

    logic win_load, win_clr, win_dec, win_zero, win_last;
    logic fan_load, fan_dec, fan_zero, fan_last;
    logic quiet_load, quiet_dec, quiet_zero, quiet_last;

    assign hits_inc = hits + 4'd1;

    always_comb begin
        state_n    = state;
        hits_n     = hits;
        buzzer_n   = buzzer;
        win_load   = 1'b0;
        win_clr    = 1'b0;
        win_dec    = 1'b0;
        fan_load   = 1'b0;
        fan_dec    = 1'b0;
        quiet_load = 1'b0;
        quiet_dec  = 1'b0;
        case (state)
            ST_IDLE: begin
                buzzer_n = 1'b0;
                if (det) begin
                    state_n  = ST_VENT;
                    hits_n   = 4'd1;
                    win_load = 1'b1;
                    fan_load = 1'b1;
                end
            end
            ST_VENT: begin
                buzzer_n = 1'b0;
                if (det) begin
                    // a detection always wins over a same-cycle tick
                    fan_load = 1'b1;
                    win_load = win_zero;
                    if (hits_inc == HIT_THR_V) begin
                        state_n  = ST_ALARM;
                        hits_n   = 4'd0;
                        buzzer_n = 1'b1;
                    end else begin
                        hits_n = hits_inc;
                    end
                end else if (tick) begin
                    win_dec = 1'b1;
                    fan_dec = 1'b1;
                    if (win_last) begin
                        hits_n = 4'd0;
                    end
                    if (fan_last || fan_zero) begin
                        state_n = ST_IDLE;
                        hits_n  = 4'd0;
                        win_clr = 1'b1;
                    end
                end
            end
            ST_ALARM: begin
                if (ack) begin
                    state_n    = ST_HOLD;
                    buzzer_n   = 1'b0;
                    quiet_load = 1'b1;
                end else if (tick) begin
                    buzzer_n = ~buzzer;
                end
            end
            ST_HOLD: begin
                buzzer_n = 1'b0;
                if (det) begin
                    quiet_load = 1'b1;
                end else if (tick) begin
                    quiet_dec = 1'b1;
                    if (quiet_last || quiet_zero) begin
                        state_n  = ST_VENT;
                        hits_n   = 4'd0;
                        win_clr  = 1'b1;
                        fan_load = 1'b1;
                    end
                end
            end
            default: begin
                state_n  = ST_IDLE;
                hits_n   = 4'd0;
                buzzer_n = 1'b0;
                win_clr  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= ST_IDLE;
            hits      <= 4'd0;
            fan       <= 1'b0;
            alarm     <= 1'b0;
            buzzer    <= 1'b0;
            event_cnt <= '0;
        end else begin
            state  <= state_n;
            hits   <= hits_n;
            buzzer <= buzzer_n;
            fan    <= (state_n != ST_IDLE);
            alarm  <= (state_n == ST_ALARM) || (state_n == ST_HOLD);
            if (det && (event_cnt != '1)) begin
                event_cnt <= event_cnt + CNT_W'(1);
            end
        end
    end

    assign state_dbg = state;

    co2_alarm_ctrl_tick_timer u_win (
        .CLK      (CLK),
        .RST      (RST),
        .load     (win_load),
        .load_val (TMR_W'(WIN_TICKS)),
        .clr      (win_clr),
        .dec      (win_dec),
        .zero     (win_zero),
        .last     (win_last)
    );

    co2_alarm_ctrl_tick_timer u_fan_t (
        .CLK      (CLK),
        .RST      (RST),
        .load     (fan_load),
        .load_val (TMR_W'(FAN_MIN_TICKS)),
        .clr      (1'b0),
        .dec      (fan_dec),
        .zero     (fan_zero),
        .last     (fan_last)
    );

    co2_alarm_ctrl_tick_timer u_quiet (
        .CLK      (CLK),
        .RST      (RST),
        .load     (quiet_load),
        .load_val (TMR_W'(QUIET_TICKS)),
        .clr      (1'b0),
        .dec      (quiet_dec),
        .zero     (quiet_zero),
        .last     (quiet_last)
    );

endmodule

// File: tb/tb_co2_alarm_ctrl.sv
// Bench for co2_alarm_ctrl: behavioural model feeds an expected queue per cycle,
// plus directed scenarios with fixed expected values.
module tb_co2_alarm_ctrl;

    localparam int HIT_THR = 3;
    localparam int WIN     = 60;
    localparam int FAN_MIN = 30;
    localparam int QUIET   = 120;
    localparam int CNT_W   = 8;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             det = 1'b0;
    logic             tick = 1'b0;
    logic             ack = 1'b0;
    logic             fan, alarm, buzzer;
    logic [CNT_W-1:0] event_cnt;
    logic [2:0]       state_dbg;

    co2_alarm_ctrl #(
        .HIT_THR       (HIT_THR),
        .WIN_TICKS     (WIN),
        .FAN_MIN_TICKS (FAN_MIN),
        .QUIET_TICKS   (QUIET),
        .CNT_W         (CNT_W)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .det       (det),
        .tick      (tick),
        .ack       (ack),
        .fan       (fan),
        .alarm     (alarm),
        .buzzer    (buzzer),
        .event_cnt (event_cnt),
        .state_dbg (state_dbg)
    );

    always #5 CLK = ~CLK;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [13:0] exp_q[$];

    // reference model state
    int m_state, m_hits, m_win, m_fan, m_quiet, m_cnt;
    bit m_buz;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_hits = 0; m_win = 0; m_fan = 0; m_quiet = 0; m_cnt = 0; m_buz = 0;
    endtask

    task automatic model_step(input bit d, input bit t, input bit a);
        int ns;
        ns = m_state;
        case (m_state)
            0: if (d) begin
                ns = 1; m_hits = 1; m_win = WIN; m_fan = FAN_MIN;
            end
            1: if (d) begin
                m_fan = FAN_MIN;
                if (m_win == 0) m_win = WIN;
                if (m_hits + 1 == HIT_THR) begin
                    ns = 2; m_hits = 0; m_buz = 1;
                end else begin
                    m_hits++;
                end
            end else if (t) begin
                if (m_win > 0) begin
                    m_win--;
                    if (m_win == 0) m_hits = 0;
                end
                if (m_fan > 0) m_fan--;
                if (m_fan == 0) begin
                    ns = 0; m_hits = 0; m_win = 0;
                end
            end
            2: if (a) begin
                ns = 3; m_buz = 0; m_quiet = QUIET;
            end else if (t) begin
                m_buz = !m_buz;
            end
            default: if (d) begin
                m_quiet = QUIET;
            end else if (t) begin
                if (m_quiet > 0) m_quiet--;
                if (m_quiet == 0) begin
                    ns = 1; m_hits = 0; m_win = 0; m_fan = FAN_MIN;
                end
            end
        endcase
        if (d && m_cnt < 255) m_cnt++;
        m_state = ns;
    endtask

    function automatic logic [13:0] model_pack();
        logic f, al;
        f  = (m_state != 0);
        al = (m_state >= 2);
        return {f, al, m_buz, m_cnt[7:0], m_state[2:0]};
    endfunction

    // one clock: drive on the falling edge, compare just after the rising edge
    task automatic cycle(input bit d, input bit t, input bit a);
        logic [13:0] exp;
        @(negedge CLK);
        det = d; tick = t; ack = a;
        model_step(d, t, a);
        exp_q.push_back(model_pack());
        @(posedge CLK);
        #1;
        exp = exp_q.pop_front();
        check_eq("cyc", {fan, alarm, buzzer, event_cnt, state_dbg}, exp);
        det = 0; tick = 0; ack = 0;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            cycle(0, 1, 0);
            repeat ($urandom_range(0, 1)) cycle(0, 0, 0);
        end
    endtask

    task automatic apply_reset();
        @(negedge CLK);
        RST = 1; det = 1; tick = 1; ack = 0;
        model_reset();
        @(negedge CLK);
        check_eq("rst_out", {fan, alarm, buzzer, event_cnt, state_dbg}, 14'd0);
        RST = 0; det = 0; tick = 0;
    endtask

    initial begin
        apply_reset();

        // build event_cnt=5 while in VENT, then reset mid-cycle
        cycle(1, 0, 0); cycle(1, 0, 0); ticks(30);
        cycle(1, 0, 0); cycle(1, 0, 0); ticks(30);
        cycle(1, 0, 0);
        check_eq("pre_rst_fan", fan, 1);
        check_eq("pre_rst_cnt", event_cnt, 5);
        @(posedge CLK);
        #2 RST = 1;
        #1;
        check_eq("async_rst_fan", fan, 0);
        check_eq("async_rst_cnt", event_cnt, 0);
        check_eq("async_rst_state", state_dbg, 0);
        model_reset();
        @(negedge CLK);
        RST = 0;

        // single detection, minimum fan time
        cycle(1, 0, 0);
        check_eq("single_fan_on", fan, 1);
        ticks(29);
        check_eq("single_fan_hold", fan, 1);
        cycle(0, 1, 0);
        check_eq("single_fan_off", fan, 0);
        check_eq("single_idle", state_dbg, 0);

        // alarm raise and buzzer toggle
        apply_reset();
        cycle(1, 0, 0); ticks(10); cycle(1, 0, 0); ticks(10);
        check_eq("two_hits_no_alarm", alarm, 0);
        cycle(1, 0, 0);
        check_eq("raise_alarm", alarm, 1);
        check_eq("raise_buzzer", buzzer, 1);
        check_eq("raise_cnt", event_cnt, 3);
        cycle(0, 1, 0);
        check_eq("buz_toggle0", buzzer, 0);
        cycle(0, 1, 0);
        check_eq("buz_toggle1", buzzer, 1);

        // acknowledge, quiet reload and release
        cycle(0, 0, 1);
        check_eq("ack_buzzer", buzzer, 0);
        check_eq("ack_alarm", alarm, 1);
        check_eq("ack_state", state_dbg, 3);
        ticks(100);
        cycle(1, 0, 0);
        ticks(119);
        check_eq("quiet_hold", alarm, 1);
        cycle(0, 1, 0);
        check_eq("release_alarm", alarm, 0);
        check_eq("release_fan", fan, 1);
        ticks(29);
        check_eq("release_fan_min", fan, 1);
        cycle(0, 1, 0);
        check_eq("release_idle", state_dbg, 0);

        // detections separated by a full window do not accumulate
        apply_reset();
        cycle(1, 0, 0); ticks(60);
        cycle(1, 0, 0); cycle(1, 0, 0);
        check_eq("win_no_alarm", alarm, 0);
        cycle(1, 0, 0);
        check_eq("win_third_alarm", alarm, 1);

        // det beats tick when fan_t is about to expire
        apply_reset();
        cycle(1, 0, 0); ticks(29);
        cycle(1, 1, 0);
        check_eq("prio_stay_vent", state_dbg, 1);
        ticks(29);
        check_eq("prio_fan_reload", state_dbg, 1);
        cycle(0, 1, 0);
        check_eq("prio_expire", state_dbg, 0);

        // ack outside ALARM, counter saturation, ack beats det
        apply_reset();
        cycle(0, 0, 1);
        check_eq("ack_ignored", state_dbg, 0);
        repeat (260) cycle(1, 0, 0);
        check_eq("sat_cnt", event_cnt, 255);
        check_eq("sat_state", state_dbg, 2);
        cycle(1, 0, 1);
        check_eq("ack_det_state", state_dbg, 3);
        check_eq("ack_det_cnt", event_cnt, 255);

        // randomised traffic against the model
        apply_reset();
        for (int i = 0; i < 1500; i++) begin
            cycle($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
        end

        check_eq("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
